// File: rtl/aes_inv_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_key_sched (with helper aes_sbox)
// Purpose  : Reverse AES-128 key schedule. Loaded with the round-10 key, each
//            step yields the previous round key down to round 0 (cipher key),
//            generating the inverse Rcon sequence from the registered round.
// Ports    : clk     - rising-edge clock
//            rst_n   - asynchronous active-low reset
//            kld     - load key_in as round-NR key (priority over step)
//            key_in  - last round key, word 0 in [127:96]
//            step    - request previous-round key, honoured when ready=1
//            rkey    - current round key, word 0 in [127:96]
//            round   - round number of rkey (NR..0)
//            rcon    - Rcon used to reach rkey ({byte,24'h0}), 0 after load
//            ready   - rkey valid and schedule can step
//            done    - rkey is round 0, no further steps
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// aes_sbox : forward AES S-box, pure combinational lookup.
// ----------------------------------------------------------------------------
module aes_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  // Entry 0 sits in the most significant byte.
  localparam logic [0:255][7:0] c_SBOX = {
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  assign o_s = c_SBOX[i_a];
endmodule

// ----------------------------------------------------------------------------
// aes_inv_key_sched : reverse AES-128 key expansion, one round per step.
// ----------------------------------------------------------------------------
module aes_inv_key_sched #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         kld,
  input  logic [127:0] key_in,
  input  logic         step,
  output logic [127:0] rkey,
  output logic [3:0]   round,
  output logic [31:0]  rcon,
  output logic         ready,
  output logic         done
);
  localparam logic [3:0] c_NR = 4'(NR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2
  } state_t;

  state_t       r_state;
  logic [127:0] r_rkey;
  logic [3:0]   r_round;
  logic [31:0]  r_rcon;
  logic         r_ready;
  logic         r_done;

  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_p0, w_p1, w_p2, w_p3;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [7:0]   w_rc;

  assign w_w0 = r_rkey[127:96];
  assign w_w1 = r_rkey[95:64];
  assign w_w2 = r_rkey[63:32];
  assign w_w3 = r_rkey[31:0];

  // Undo the forward recurrence w[i] = w[i-4] ^ w[i-1] for words 1..3; word 0
  // needs the recovered previous word 3 (p3) through RotWord/SubWord.
  assign w_p3  = w_w3 ^ w_w2;
  assign w_p2  = w_w2 ^ w_w1;
  assign w_p1  = w_w1 ^ w_w0;
  assign w_rot = {w_p3[23:0], w_p3[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    aes_sbox u_sbox (
      .i_a (w_rot[8*gi +: 8]),
      .o_s (w_sub[8*gi +: 8])
    );
  end

  // Rcon byte for the key of the registered round.
  always_comb begin
    w_rc = 8'h00;
    case (r_round)
      4'd1:    w_rc = 8'h01;
      4'd2:    w_rc = 8'h02;
      4'd3:    w_rc = 8'h04;
      4'd4:    w_rc = 8'h08;
      4'd5:    w_rc = 8'h10;
      4'd6:    w_rc = 8'h20;
      4'd7:    w_rc = 8'h40;
      4'd8:    w_rc = 8'h80;
      4'd9:    w_rc = 8'h1b;
      4'd10:   w_rc = 8'h36;
      default: w_rc = 8'h00;
    endcase
  end

  assign w_p0 = w_w0 ^ w_sub ^ {w_rc, 24'h0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rkey  <= '0;
      r_round <= '0;
      r_rcon  <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else if (kld) begin
      r_state <= S_RUN;
      r_rkey  <= key_in;
      r_round <= c_NR;
      r_rcon  <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          r_done  <= 1'b0;
        end
        S_RUN: begin
          if (r_round > c_NR) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
          end else if (r_round == 4'd0) begin
            // Defensive: a RUN state at round 0 settles into LAST.
            r_state <= S_LAST;
            r_ready <= 1'b0;
            r_done  <= 1'b1;
          end else if (step) begin
            r_rkey  <= {w_p0, w_p1, w_p2, w_p3};
            r_round <= r_round - 4'd1;
            r_rcon  <= {w_rc, 24'h0};
            if (r_round == 4'd1) begin
              r_state <= S_LAST;
              r_ready <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_LAST: begin
          if (r_round > c_NR) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign rkey  = r_rkey;
  assign round = r_round;
  assign rcon  = r_rcon;
  assign ready = r_ready;
  assign done  = r_done;
endmodule
`default_nettype wire
